// File: rtl/uart_rx.sv
// UART receive channel. It oversamples sdata_rx_in on clock_out, which runs at BAUDRATE*OVERSAMPLING, and samples each bit at its centre.
// Latency: the byte appears on data_rx_out/valid_rx_out one clock after the stop-bit centre sample.
// Backpressure: one output register. A good frame that arrives while that register is still full is dropped, and overrun_error_out pulses.
//
// Ports:
//   clock_out         baud-oversampling clock
//   nreset            asynchronous active-low reset
//   sdata_rx_in       asynchronous serial line, idles high
//   ready_rx_in       consumer accepts data_rx_out when valid_rx_out is high
//   data_rx_out       received byte, stable while valid_rx_out is high
//   valid_rx_out      data_rx_out holds an unconsumed byte
//   frame_error_out   one-cycle pulse: stop bit sampled low
//   overrun_error_out one-cycle pulse: good frame dropped, output register full
//   busy_rx_out       high while the receiver is not idle
module uart_rx #(
    parameter int BYTESIZES    = 8,
    parameter int OVERSAMPLING = 16
) (
    input  logic                 clock_out,
    input  logic                 nreset,
    input  logic                 sdata_rx_in,
    input  logic                 ready_rx_in,
    output logic [BYTESIZES-1:0] data_rx_out,
    output logic                 valid_rx_out,
    output logic                 frame_error_out,
    output logic                 overrun_error_out,
    output logic                 busy_rx_out
);

    localparam int CW  = $clog2(OVERSAMPLING);
    localparam int BIW = (BYTESIZES > 1) ? $clog2(BYTESIZES) : 1;

    localparam logic [CW-1:0]  CNT_HALF = CW'(OVERSAMPLING / 2 - 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(OVERSAMPLING - 1);
    localparam logic [BIW-1:0] BIT_LAST = BIW'(BYTESIZES - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [BIW-1:0]         bit_idx;
    logic [BYTESIZES-1:0]   shift_reg;
    logic                   deliver;
    logic                   rx_meta;
    logic                   rx_s;

    // Both synchronizer stages reset to the idle line level.
    // This stops a spurious start bit from being detected when reset is released.
    always_ff @(posedge clock_out or negedge nreset) begin
        if (!nreset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= sdata_rx_in;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clock_out or negedge nreset) begin
        if (!nreset) begin
            state             <= IDLE;
            cnt               <= '0;
            bit_idx           <= '0;
            shift_reg         <= '0;
            deliver           <= 1'b0;
            data_rx_out       <= '0;
            valid_rx_out      <= 1'b0;
            frame_error_out   <= 1'b0;
            overrun_error_out <= 1'b0;
            busy_rx_out       <= 1'b0;
        end else begin
            frame_error_out   <= 1'b0;
            overrun_error_out <= 1'b0;
            deliver           <= 1'b0;
            cnt               <= cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state       <= START;
                        cnt         <= '0;
                        busy_rx_out <= 1'b1;
                    end
                end

                // Re-check the line at the centre of the start bit.
                // A low that has already gone away is noise, so it is ignored without raising any flag.
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state       <= IDLE;
                            busy_rx_out <= 1'b0;
                        end else begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end
                    end
                end

                // From here on, a full bit period after each centre sample lands on the centre of the next bit.
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt                <= '0;
                        shift_reg[bit_idx] <= rx_s;
                        bit_idx            <= bit_idx + 1'b1;
                        if (bit_idx == BIT_LAST) begin
                            state <= STOP;
                        end
                    end
                end

                // The FSM returns to IDLE at the stop-bit centre.
                // This leaves half a bit period to catch the start edge of a back-to-back frame.
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            deliver     <= 1'b1;
                            state       <= IDLE;
                            busy_rx_out <= 1'b0;
                        end else begin
                            frame_error_out <= 1'b1;
                            state           <= WAIT_HIGH;
                        end
                    end
                end

                // A break or stuck-low line must not be treated as a fresh start bit.
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state       <= IDLE;
                        cnt         <= '0;
                        busy_rx_out <= 1'b0;
                    end
                end

                default: begin
                    state       <= IDLE;
                    cnt         <= '0;
                    busy_rx_out <= 1'b0;
                end
            endcase

            // Output register.
            // A byte being consumed in this same cycle frees the slot for the new delivery.
            if (deliver) begin
                if (!valid_rx_out || ready_rx_in) begin
                    data_rx_out  <= shift_reg;
                    valid_rx_out <= 1'b1;
                end else begin
                    overrun_error_out <= 1'b1;
                end
            end else if (valid_rx_out && ready_rx_in) begin
                valid_rx_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at 8 data bits, OVERSAMPLING=16.
// A behavioural serializer drives the line.
// A negedge monitor collects accepted bytes and flag pulses.
module tb_uart_rx;

    localparam int OS = 16;

    logic       clock_out = 1'b0;
    logic       nreset;
    logic       sdata_rx_in;
    logic       ready_rx_in;
    logic [7:0] data_rx_out;
    logic       valid_rx_out;
    logic       frame_error_out;
    logic       overrun_error_out;
    logic       busy_rx_out;

    int tests = 0;
    int fails = 0;

    logic [7:0] rx_q[$];
    int         valid_cycles;
    int         fe_cnt;
    int         ov_cnt;
    int         clash_cnt;

    uart_rx #(.BYTESIZES(8), .OVERSAMPLING(OS)) dut (
        .clock_out         (clock_out),
        .nreset            (nreset),
        .sdata_rx_in       (sdata_rx_in),
        .ready_rx_in       (ready_rx_in),
        .data_rx_out       (data_rx_out),
        .valid_rx_out      (valid_rx_out),
        .frame_error_out   (frame_error_out),
        .overrun_error_out (overrun_error_out),
        .busy_rx_out       (busy_rx_out)
    );

    always #5 clock_out = ~clock_out;

    // Sample outputs midway between active edges.
    always @(negedge clock_out) begin
        if (nreset) begin
            if (valid_rx_out) valid_cycles++;
            if (valid_rx_out && ready_rx_in) rx_q.push_back(data_rx_out);
            if (frame_error_out) fe_cnt++;
            if (overrun_error_out) ov_cnt++;
            if (frame_error_out && (overrun_error_out || valid_rx_out)) clash_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        rx_q.delete();
        valid_cycles = 0;
        fe_cnt       = 0;
        ov_cnt       = 0;
    endtask

    // Drive one bit period, changing the line 1 ns after an active edge.
    task automatic bit_time(input logic v);
        sdata_rx_in = v;
        repeat (OS) @(posedge clock_out);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        bit_time(stop);
    endtask

    initial begin
        clash_cnt   = 0;
        clear_mon();
        nreset      = 1'b0;
        ready_rx_in = 1'b1;
        sdata_rx_in = 1'b1;

        // Reset held with line toggling.
        for (int i = 0; i < 10; i++) begin
            @(posedge clock_out); #1;
            sdata_rx_in = ~sdata_rx_in;
        end
        check("rst_data",  {24'd0, data_rx_out}, 32'h00);
        check("rst_valid", {31'd0, valid_rx_out}, 32'd0);
        check("rst_fe",    {31'd0, frame_error_out}, 32'd0);
        check("rst_ov",    {31'd0, overrun_error_out}, 32'd0);
        check("rst_busy",  {31'd0, busy_rx_out}, 32'd0);
        sdata_rx_in = 1'b1;
        @(posedge clock_out); #1;
        nreset = 1'b1;
        repeat (40) @(posedge clock_out);
        #1;
        check("idle_busy",   {31'd0, busy_rx_out}, 32'd0);
        check("idle_nvalid", valid_cycles, 32'd0);

        // Single frame 0xA5, consumer always ready.
        clear_mon();
        send_frame(8'hA5, 1'b1);
        bit_time(1'b1); bit_time(1'b1);
        check("a5_count",  rx_q.size(), 32'd1);
        if (rx_q.size() > 0) check("a5_data", {24'd0, rx_q[0]}, 32'hA5);
        check("a5_vcycles", valid_cycles, 32'd1);
        check("a5_fe",      fe_cnt, 32'd0);
        check("a5_ov",      ov_cnt, 32'd0);

        // Glitch: four low ticks only.
        clear_mon();
        sdata_rx_in = 1'b0;
        repeat (4) @(posedge clock_out);
        #1;
        bit_time(1'b1); bit_time(1'b1);
        check("glitch_busy",  {31'd0, busy_rx_out}, 32'd0);
        check("glitch_valid", valid_cycles, 32'd0);
        check("glitch_fe",    fe_cnt, 32'd0);
        send_frame(8'h3C, 1'b1);
        bit_time(1'b1);
        check("3c_count", rx_q.size(), 32'd1);
        if (rx_q.size() > 0) check("3c_data", {24'd0, rx_q[0]}, 32'h3C);

        // Frame error, then the line is held low.
        clear_mon();
        send_frame(8'h55, 1'b0);
        bit_time(1'b0); bit_time(1'b0); bit_time(1'b0);
        check("fe_pulse",   fe_cnt, 32'd1);
        check("fe_novalid", valid_cycles, 32'd0);
        check("fe_waitbusy", {31'd0, busy_rx_out}, 32'd1);
        bit_time(1'b1); bit_time(1'b1);
        check("fe_idle", {31'd0, busy_rx_out}, 32'd0);
        send_frame(8'h81, 1'b1);
        bit_time(1'b1);
        check("81_count", rx_q.size(), 32'd1);
        if (rx_q.size() > 0) check("81_data", {24'd0, rx_q[0]}, 32'h81);
        check("81_fe", fe_cnt, 32'd1);

        // Overrun: consumer stalled across two back-to-back frames.
        clear_mon();
        ready_rx_in = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        bit_time(1'b1); bit_time(1'b1);
        check("ov_valid", {31'd0, valid_rx_out}, 32'd1);
        check("ov_data",  {24'd0, data_rx_out}, 32'h11);
        check("ov_pulse", ov_cnt, 32'd1);
        check("ov_fe",    fe_cnt, 32'd0);
        ready_rx_in = 1'b1;
        repeat (2) @(posedge clock_out);
        #1;
        check("ov_cleared", {31'd0, valid_rx_out}, 32'd0);
        check("ov_count",   rx_q.size(), 32'd1);
        if (rx_q.size() > 0) check("ov_popped", {24'd0, rx_q[0]}, 32'h11);

        // Back-to-back stream from a transmitter.
        clear_mon();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h5A, 1'b1);
        bit_time(1'b1);
        check("lb_count", rx_q.size(), 32'd3);
        if (rx_q.size() == 3) begin
            check("lb_b0", {24'd0, rx_q[0]}, 32'h00);
            check("lb_b1", {24'd0, rx_q[1]}, 32'hFF);
            check("lb_b2", {24'd0, rx_q[2]}, 32'h5A);
        end
        check("lb_fe", fe_cnt, 32'd0);
        check("lb_ov", ov_cnt, 32'd0);

        // Reset in the middle of a frame.
        clear_mon();
        bit_time(1'b0); bit_time(1'b1); bit_time(1'b1);
        nreset      = 1'b0;
        sdata_rx_in = 1'b1;
        repeat (5) @(posedge clock_out);
        #1;
        check("mid_rst_busy", {31'd0, busy_rx_out}, 32'd0);
        nreset = 1'b1;
        bit_time(1'b1);
        check("mid_rst_idle", {31'd0, busy_rx_out}, 32'd0);
        send_frame(8'hC3, 1'b1);
        bit_time(1'b1);
        check("mid_rst_count", rx_q.size(), 32'd1);
        if (rx_q.size() > 0) check("mid_rst_data", {24'd0, rx_q[0]}, 32'hC3);
        check("mid_rst_fe", fe_cnt, 32'd0);

        check("no_flag_clash", clash_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
